// File: rtl/jt12_bus_master_if.sv
`default_nettype none
// jt12_bus_master_if: request-side and chip-side signals of jt12_bus_master.
// Rev 1.0
interface jt12_bus_master_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_part;
  logic [7:0]            req_reg;
  logic [7:0]            req_val;
  logic [DEPTH_LOG2:0]   level;
  logic                  idle;
  logic [7:0]            din;
  logic [1:0]            addr;
  logic                  write;
  logic                  busy;

  modport master (
    input  req_valid, req_part, req_reg, req_val, busy,
    output req_ready, level, idle, din, addr, write
  );

  modport slave (
    output req_valid, req_part, req_reg, req_val, busy,
    input  req_ready, level, idle, din, addr, write
  );
endinterface
`default_nettype wire

// File: rtl/jt12_bus_master.sv
`default_nettype none
// jt12_bus_master: FIFO-buffered register-write initiator for the JT12 CPU port.
// Rev 1.0
module jt12_bus_master #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_CACHE = 1
) (
  input  logic              clk,
  input  logic              rst,
  jt12_bus_master_if.master bus
);
  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic                USE_CACHE  = (ADDR_CACHE != 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    AGAP = 3'd2,
    DATA = 3'd3,
    DGAP = 3'd4
  } state_t;

  state_t                state;
  logic [16:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  gap_first;
  logic                  cache_vld;
  logic [8:0]            cache;
  logic [7:0]            din_q;
  logic [7:0]            val_q;
  logic [1:0]            addr_q;
  logic                  write_q;

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  gap_done;
  logic                  cache_hit;
  logic                  head_part;
  logic [7:0]            head_reg;
  logic [7:0]            head_val;

  assign empty         = (count == '0);
  assign full          = (count == FULL_LEVEL);
  assign bus.req_ready = !full && !rst;
  assign push          = bus.req_valid && bus.req_ready;
  assign {head_part, head_reg, head_val} = mem[rd_ptr];

  // The first gap cycle is a guard: the chip's busy has not risen yet.
  assign gap_done  = !gap_first && !bus.busy;
  assign pop       = !empty && (((state == IDLE) && !bus.busy) || ((state == DGAP) && gap_done));
  assign cache_hit = USE_CACHE && cache_vld && (cache == {head_part, head_reg});

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.req_part, bus.req_reg, bus.req_val};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap_first <= 1'b0;
      cache_vld <= 1'b0;
      cache     <= '0;
      din_q     <= '0;
      val_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      case (state)
        IDLE, DGAP: begin
          gap_first <= 1'b0;
          if (pop) begin
            val_q   <= head_val;
            write_q <= 1'b1;
            if (cache_hit) begin
              state  <= DATA;
              din_q  <= head_val;
              addr_q <= {head_part, 1'b1};
            end else begin
              state  <= ADDR;
              din_q  <= head_reg;
              addr_q <= {head_part, 1'b0};
            end
          end else if ((state == DGAP) && gap_done) begin
            state <= IDLE;
          end
        end
        ADDR: begin
          cache     <= {addr_q[1], din_q};
          cache_vld <= 1'b1;
          gap_first <= 1'b1;
          state     <= AGAP;
        end
        AGAP: begin
          gap_first <= 1'b0;
          if (gap_done) begin
            din_q   <= val_q;
            addr_q  <= {addr_q[1], 1'b1};
            write_q <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          gap_first <= 1'b1;
          state     <= DGAP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.level = count;
  assign bus.idle  = empty && (state == IDLE);
  assign bus.din   = din_q;
  assign bus.addr  = addr_q;
  assign bus.write = write_q;
endmodule
`default_nettype wire

// File: tb/tb_jt12_bus_master.sv
`default_nettype none
// tb_jt12_bus_master: directed bench with a chip model whose busy follows each write strobe.
module tb_jt12_bus_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  jt12_bus_master_if #(.DEPTH_LOG2(4)) bus_a ();
  jt12_bus_master_if #(.DEPTH_LOG2(2)) bus_b ();

  jt12_bus_master #(.DEPTH_LOG2(4), .ADDR_CACHE(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  jt12_bus_master #(.DEPTH_LOG2(2), .ADDR_CACHE(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Chip model: busy rises the cycle after a write and stays high for len cycles.
  int   len_a  = 1;
  int   cnt_a  = 0;
  int   cnt_b  = 0;
  logic hold_b = 1'b0;
  assign bus_a.busy = (cnt_a != 0);
  assign bus_b.busy = hold_b || (cnt_b != 0);
  always @(posedge clk) begin
    if (bus_a.write === 1'b1) cnt_a <= len_a;
    else if (cnt_a > 0)       cnt_a <= cnt_a - 1;
    if (bus_b.write === 1'b1) cnt_b <= 1;
    else if (cnt_b > 0)       cnt_b <= cnt_b - 1;
  end

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    int         c;
  } pulse_t;
  pulse_t log_a[$];
  pulse_t log_b[$];
  always @(negedge clk) begin
    if (bus_a.write === 1'b1) log_a.push_back('{bus_a.addr, bus_a.din, cyc});
    if (bus_b.write === 1'b1) log_b.push_back('{bus_b.addr, bus_b.din, cyc});
  end

  // which: 0 = dut_a, 1 = dut_b, 2 = both; t = cycle in which the request is offered
  task automatic push(input int which, input logic p, input logic [7:0] r, input logic [7:0] v,
                      output int t);
    @(negedge clk);
    t = cyc;
    if (which != 1) begin
      bus_a.req_valid = 1'b1; bus_a.req_part = p; bus_a.req_reg = r; bus_a.req_val = v;
    end
    if (which != 0) begin
      bus_b.req_valid = 1'b1; bus_b.req_part = p; bus_b.req_reg = r; bus_b.req_val = v;
    end
    @(posedge clk);
    #1;
    bus_a.req_valid = 1'b0;
    bus_b.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (!(bus_a.idle === 1'b1 && bus_b.idle === 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      fails++;
      $display("FAIL wait_idle: idle_a=%b idle_b=%b after %0d cycles, required 1/1", bus_a.idle, bus_b.idle, limit);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus_a.req_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready_in_rst: got %b required 0", bus_a.req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.req_ready !== 1'b1 || bus_a.idle !== 1'b1 || bus_a.level !== 5'd0) begin
      fails++;
      $display("FAIL reset_status: ready=%b idle=%b level=%0d required 1 1 0", bus_a.req_ready, bus_a.idle, bus_a.level);
    end
    checks++;
    if (bus_a.write !== 1'b0 || bus_a.din !== 8'h00 || bus_a.addr !== 2'b00) begin
      fails++;
      $display("FAIL reset_bus: write=%b din=%h addr=%b required 0 00 00", bus_a.write, bus_a.din, bus_a.addr);
    end
  endtask

  task automatic test_single();
    int t0;
    log_a.delete();
    push(0, 1'b0, 8'h28, 8'hF0, t0);
    while (cyc < t0 + 7) @(negedge clk);
    checks++;
    if (bus_a.idle !== 1'b0) begin
      fails++; $display("FAIL single_idle_c7: got %b required 0", bus_a.idle);
    end
    @(negedge clk);
    checks++;
    if (bus_a.idle !== 1'b1) begin
      fails++; $display("FAIL single_idle_c8: got %b required 1", bus_a.idle);
    end
    checks++;
    if (log_a.size() != 2) begin
      fails++; $display("FAIL single_count: got %0d pulses required 2", log_a.size());
    end else begin
      checks++;
      if (log_a[0].a !== 2'b00 || log_a[0].d !== 8'h28 || log_a[0].c != t0 + 2) begin
        fails++;
        $display("FAIL single_addr_pulse: got addr=%b din=%h cyc=%0d required 00 28 %0d", log_a[0].a, log_a[0].d, log_a[0].c, t0 + 2);
      end
      checks++;
      if (log_a[1].a !== 2'b01 || log_a[1].d !== 8'hF0 || log_a[1].c != t0 + 5) begin
        fails++;
        $display("FAIL single_data_pulse: got addr=%b din=%h cyc=%0d required 01 f0 %0d", log_a[1].a, log_a[1].d, log_a[1].c, t0 + 5);
      end
    end
  endtask

  task automatic test_cache_hit();
    int t;
    log_a.delete();
    log_b.delete();
    push(2, 1'b0, 8'h2A, 8'h80, t);
    push(2, 1'b0, 8'h2A, 8'h81, t);
    wait_idle(100);
    checks++;
    if (log_a.size() != 3) begin
      fails++; $display("FAIL cache_hit_count: got %0d pulses required 3", log_a.size());
    end else begin
      checks++;
      if (log_a[0].a !== 2'b00 || log_a[0].d !== 8'h2A || log_a[1].a !== 2'b01 || log_a[1].d !== 8'h80 ||
          log_a[2].a !== 2'b01 || log_a[2].d !== 8'h81) begin
        fails++;
        $display("FAIL cache_hit_seq: got %b/%h %b/%h %b/%h required 00/2a 01/80 01/81",
                 log_a[0].a, log_a[0].d, log_a[1].a, log_a[1].d, log_a[2].a, log_a[2].d);
      end
      checks++;
      if (log_a[2].c - log_a[1].c != 3) begin
        fails++; $display("FAIL cache_hit_spacing: got %0d cycles required 3", log_a[2].c - log_a[1].c);
      end
    end
    checks++;
    if (log_b.size() != 4) begin
      fails++; $display("FAIL nocache_count: got %0d pulses required 4", log_b.size());
    end else begin
      checks++;
      if (log_b[0].a !== 2'b00 || log_b[0].d !== 8'h2A || log_b[1].a !== 2'b01 || log_b[1].d !== 8'h80 ||
          log_b[2].a !== 2'b00 || log_b[2].d !== 8'h2A || log_b[3].a !== 2'b01 || log_b[3].d !== 8'h81) begin
        fails++;
        $display("FAIL nocache_seq: got %b/%h %b/%h %b/%h %b/%h required 00/2a 01/80 00/2a 01/81",
                 log_b[0].a, log_b[0].d, log_b[1].a, log_b[1].d, log_b[2].a, log_b[2].d, log_b[3].a, log_b[3].d);
      end
    end
  endtask

  // Cache still holds {0,0x2A}, so the first request is a hit and the part change is a miss.
  task automatic test_part_change();
    int t;
    log_a.delete();
    push(0, 1'b0, 8'h2A, 8'h10, t);
    push(0, 1'b1, 8'h2A, 8'h20, t);
    wait_idle(100);
    checks++;
    if (log_a.size() != 3) begin
      fails++; $display("FAIL part_change_count: got %0d pulses required 3", log_a.size());
    end else begin
      checks++;
      if (log_a[0].a !== 2'b01 || log_a[0].d !== 8'h10 || log_a[1].a !== 2'b10 || log_a[1].d !== 8'h2A ||
          log_a[2].a !== 2'b11 || log_a[2].d !== 8'h20) begin
        fails++;
        $display("FAIL part_change_seq: got %b/%h %b/%h %b/%h required 01/10 10/2a 11/20",
                 log_a[0].a, log_a[0].d, log_a[1].a, log_a[1].d, log_a[2].a, log_a[2].d);
      end
    end
  endtask

  task automatic test_long_busy();
    int   t0;
    int   n = 0;
    logic stable = 1'b1;
    len_a = 50;
    log_a.delete();
    push(0, 1'b0, 8'h30, 8'h55, t0);
    while (n < 300 && !(bus_a.idle === 1'b1 && cyc - t0 >= 10)) begin
      @(negedge clk);
      n++;
      if (cyc - t0 >= 3 && cyc - t0 <= 53 &&
          (bus_a.write !== 1'b0 || bus_a.din !== 8'h30 || bus_a.addr !== 2'b00)) stable = 1'b0;
    end
    len_a = 1;
    checks++;
    if (n >= 300) begin
      fails++; $display("FAIL long_busy_timeout: idle=%b required 1", bus_a.idle);
    end
    checks++;
    if (stable !== 1'b1) begin
      fails++; $display("FAIL long_busy_stable: got %b required 1", stable);
    end
    checks++;
    if (log_a.size() != 2) begin
      fails++; $display("FAIL long_busy_count: got %0d pulses required 2", log_a.size());
    end else begin
      checks++;
      if (log_a[0].c != t0 + 2 || log_a[1].c != t0 + 54 || log_a[1].a !== 2'b01 || log_a[1].d !== 8'h55) begin
        fails++;
        $display("FAIL long_busy_timing: got cyc %0d,%0d data %b/%h required %0d,%0d 01/55",
                 log_a[0].c, log_a[1].c, log_a[1].a, log_a[1].d, t0 + 2, t0 + 54);
      end
    end
  endtask

  task automatic test_fifo_full();
    int   prev = 4;
    int   n = 0;
    logic mono = 1'b1;
    hold_b = 1'b1;
    log_b.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus_b.req_ready !== (i < 4)) begin
        fails++; $display("FAIL fifo_full_ready%0d: got %b required %b", i, bus_b.req_ready, (i < 4));
      end
      bus_b.req_valid = 1'b1;
      bus_b.req_part  = 1'b0;
      bus_b.req_reg   = 8'h40 + 8'(i);
      bus_b.req_val   = 8'h60 + 8'(i);
      @(posedge clk);
      #1;
      bus_b.req_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bus_b.level !== 3'd4) begin
      fails++; $display("FAIL fifo_full_level: got %0d required 4", bus_b.level);
    end
    hold_b = 1'b0;
    while (bus_b.idle !== 1'b1 && n < 200) begin
      @(negedge clk);
      if (int'(bus_b.level) > prev) mono = 1'b0;
      prev = int'(bus_b.level);
      n++;
    end
    checks++;
    if (n >= 200 || mono !== 1'b1 || bus_b.level !== 3'd0) begin
      fails++;
      $display("FAIL fifo_drain: cycles=%0d monotonic=%b level=%0d required <200 1 0", n, mono, bus_b.level);
    end
    checks++;
    if (log_b.size() != 8) begin
      fails++; $display("FAIL fifo_drain_count: got %0d pulses required 8", log_b.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (log_b[2*k].a !== 2'b00 || log_b[2*k].d !== 8'h40 + 8'(k) ||
            log_b[2*k+1].a !== 2'b01 || log_b[2*k+1].d !== 8'h60 + 8'(k)) begin
          fails++;
          $display("FAIL fifo_order%0d: got %b/%h %b/%h required 00/%h 01/%h", k, log_b[2*k].a, log_b[2*k].d,
                   log_b[2*k+1].a, log_b[2*k+1].d, 8'h40 + 8'(k), 8'h60 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int t;
    push(0, 1'b0, 8'h2A, 8'h77, t0);
    push(0, 1'b0, 8'h2B, 8'h78, t);
    while (cyc < t0 + 3) @(negedge clk);
    checks++;
    if (bus_a.level !== 5'd1 || bus_a.idle !== 1'b0) begin
      fails++; $display("FAIL reset_mid_pre: level=%0d idle=%b required 1 0", bus_a.level, bus_a.idle);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.req_ready !== 1'b0) begin
      fails++; $display("FAIL reset_mid_ready: got %b required 0", bus_a.req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.write !== 1'b0 || bus_a.level !== 5'd0 || bus_a.idle !== 1'b1 || bus_a.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_post: write=%b level=%0d idle=%b ready=%b required 0 0 1 1",
               bus_a.write, bus_a.level, bus_a.idle, bus_a.req_ready);
    end
    log_a.delete();
    push(0, 1'b0, 8'h2A, 8'h99, t);
    wait_idle(100);
    checks++;
    if (log_a.size() != 2) begin
      fails++; $display("FAIL reset_mid_repush_count: got %0d pulses required 2", log_a.size());
    end else begin
      checks++;
      if (log_a[0].a !== 2'b00 || log_a[0].d !== 8'h2A || log_a[1].a !== 2'b01 || log_a[1].d !== 8'h99) begin
        fails++;
        $display("FAIL reset_mid_repush_seq: got %b/%h %b/%h required 00/2a 01/99",
                 log_a[0].a, log_a[0].d, log_a[1].a, log_a[1].d);
      end
    end
  endtask

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_part = 1'b0; bus_a.req_reg = 8'h00; bus_a.req_val = 8'h00;
    bus_b.req_valid = 1'b0; bus_b.req_part = 1'b0; bus_b.req_reg = 8'h00; bus_b.req_val = 8'h00;
    test_reset();
    test_single();
    test_cache_hit();
    test_part_change();
    test_long_busy();
    test_fifo_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/jt12_bus_master.md
# jt12_bus_master

Host-side initiator for the JT12 CPU register port. It accepts queued register writes from a sequencer such as a VGM player, DAC streamer or test harness. Each request is {part, register, value}, buffered in a small FIFO. The block turns each request into the chip's two-phase address/data write sequence on `din`/`addr`/`write`, honouring the chip's `busy` handshake. An optional address cache skips the address phase when the chip's selected register already matches, e.g. for back-to-back DAC writes to 0x2A.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 entries.
- ADDR_CACHE, 1: 1 skips the address phase on a {part,reg} cache hit; 0 always issues it.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept. Equals !full && !rst.
- req_part  in  1  0 = registers 0x00-0xFF part I; 1 = part II (drives addr[1]).
- req_reg  in  8  register number.
- req_val  in  8  data value.
- level  out  DEPTH_LOG2+1  FIFO occupancy.
- idle  out  1  FIFO empty and FSM in IDLE.
- din  out  8  chip data bus, registered.
- addr  out  2  chip address: {part, 0} for the address phase, {part, 1} for the data phase. Registered.
- write  out  1  chip write strobe, registered, single-cycle pulse.
- busy  in  1  chip busy, registered by the chip. Rises the cycle after an accepted write.

## Operation
- **Push:** on req_valid && req_ready, store {part,reg,val}. Simultaneous push and pop is allowed, and level stays unchanged. A push while full cannot happen because ready is 0.
- **FSM states:** IDLE, ADDR, AGAP, DATA, DGAP.
- **IDLE / DGAP exit condition:** exit only when the FIFO is non-empty, busy==0 is sampled, and (in DGAP) the guard cycle has elapsed. On exit, pop the head entry.
  - Cache miss, or ADDR_CACHE=0: go to ADDR. Load din=reg and addr={part,0}.
  - Cache hit: go directly to DATA. Load din=val and addr={part,1}.
- **ADDR:** write=1 for exactly this cycle. Set the cache to {part,reg} and cache_vld=1. Go to AGAP.
- **AGAP:** write=0. The first cycle is an unconditional guard in which busy is ignored. From the second cycle onward, when busy==0 is sampled, load din=val and addr={part,1}, then go to DATA.
- **DATA:** write=1 for one cycle. Go to DGAP.
- **DGAP:** same guard rule as AGAP. When busy==0 is sampled, do one of the following:
  - FIFO non-empty: pop the next entry (IDLE exit rules apply).
  - FIFO empty: go to IDLE.
- **Bus stability:** din and addr stay stable from the load cycle until the next load. Only write pulses.
- **Busy stuck high:** the FSM waits indefinitely. The FIFO fills, and req_ready drops at level==2^DEPTH_LOG2.
- **Reset (synchronous, any state):**
  - FSM returns to IDLE, the FIFO is emptied, and level=0.
  - cache_vld=0.
  - write=0, din=0, addr=0.
  - req_ready=0 during the rst cycle and 1 after it.
  - idle=1 after reset.
  - A request in progress is dropped. The chip may be left with only its address phase done. The invalidated cache guarantees the next request re-issues the address phase.

## Timing
- **Single request, empty FIFO, chip busy drops immediately:**
  - Push at cycle 0.
  - IDLE decides at cycle 1.
  - ADDR write at cycle 2. AGAP guard at 3, busy sampled low at 4.
  - DATA write at cycle 5. DGAP at 6–7.
  - IDLE at 8; idle=1 from cycle 8.
- **Throughput:**
  - Cache miss: 6 cycles per request.
  - Cache hit: 3 cycles per request.
- **Extended busy:** each extra busy-high cycle in AGAP or DGAP adds one cycle.
- **Strobe spacing:** consecutive write strobes are never closer than 3 cycles apart.
- **Back-pressure:** req_ready updates combinationally from registered level, so it reflects a pop in the same cycle only via the next-cycle level.

## Test plan
- **Single write:** push {0,0x28,0xF0} with a chip model whose busy lasts 1 cycle → two write pulses:
  - addr=0, din=0x28
  - then addr=1, din=0xF0, 3 cycles later
  - idle returns to 1.
- **Cache hit:** push {0,0x2A,0x80} then {0,0x2A,0x81} → exactly 3 write pulses (A 0x2A, D 0x80, D 0x81). With ADDR_CACHE=0 → 4 pulses.
- **Part change:** push {0,0x2A,0x10} then {1,0x2A,0x20} → second request re-issues its address phase with addr=2'b10, din=0x2A, then addr=2'b11, din=0x20.
- **Long busy:** hold busy high for 50 cycles after the address pulse → no write pulse during that time. The data pulse occurs exactly 1 cycle after busy is first sampled low. din and addr stay stable throughout.
- **FIFO full:** DEPTH_LOG2=2 with busy held high; offer 6 requests → req_ready=0 at level=4. After busy releases, all accepted entries are issued in push order and level counts down to 0.
- **Reset mid-AGAP:** pulse rst → next cycle write=0, level=0, idle=1. Re-pushing the same {part,reg} issues a full address phase.
